// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver and movement-key decoder for the two-player Tron game.
// Deserialises 11-bit frames, tracks E0/F0 prefixes and maps WASD/arrows to a 5-bit code.
module ps2_keyboard #(
  parameter int         TIMEOUT_CYCLES = 5000,
  parameter logic [4:0] IDLE_CODE      = 5'h1F
) (
  input  logic       clkout,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] keystroke,
  output logic [7:0] scan_code,
  output logic       scan_valid
);

  // state   | meaning
  // IDLE    | waiting for a make code or a prefix
  // EXT     | E0 seen, next byte uses the extended table
  // BRK     | F0 seen, next byte is a normal release
  // EXT_BRK | E0 F0 seen, next byte is an extended release
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam int             IW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0]  IDLE_LOAD = IW'(TIMEOUT_CYCLES - 1);

  logic          clk_s1_q, clk_s1_d;
  logic          clk_s2_q, clk_s2_d;
  logic          clk_prev_q, clk_prev_d;
  logic          dat_s1_q, dat_s1_d;
  logic          dat_s2_q, dat_s2_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          scan_valid_q, scan_valid_d;
  logic [1:0]    state_q, state_d;
  logic [4:0]    key_q, key_d;

  logic          fall;
  logic          frame_ok;

  function automatic logic [5:0] lookup_normal(input logic [7:0] code);
    case (code)
      8'h1D:   lookup_normal = {1'b1, 5'b00100};
      8'h1B:   lookup_normal = {1'b1, 5'b00101};
      8'h1C:   lookup_normal = {1'b1, 5'b00110};
      8'h23:   lookup_normal = {1'b1, 5'b00111};
      default: lookup_normal = 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] lookup_ext(input logic [7:0] code);
    case (code)
      8'h75:   lookup_ext = {1'b1, 5'b00000};
      8'h72:   lookup_ext = {1'b1, 5'b00001};
      8'h6B:   lookup_ext = {1'b1, 5'b00010};
      8'h74:   lookup_ext = {1'b1, 5'b00011};
      default: lookup_ext = 6'd0;
    endcase
  endfunction

  assign fall = clk_prev_q & ~clk_s2_q;
  // shift_q holds start in [0], d0..d7 in [8:1], parity in [9]; stop bit is the live sample
  assign frame_ok = ~shift_q[0] & dat_s2_q & (^shift_q[9:1]);

  always_comb begin
    clk_s1_d     = ps2_clk;
    clk_s2_d     = clk_s1_q;
    clk_prev_d   = clk_s2_q;
    dat_s1_d     = ps2_data;
    dat_s2_d     = dat_s1_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    idle_cnt_d   = idle_cnt_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;

    if (fall) begin
      idle_cnt_d = IDLE_LOAD;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (frame_ok) begin
          scan_code_d  = shift_q[8:1];
          scan_valid_d = 1'b1;
        end
      end else begin
        shift_d   = {dat_s2_q, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (idle_cnt_q != '0) begin
      idle_cnt_d = idle_cnt_q - IW'(1);
    end else begin
      bit_cnt_d = 4'd0;
    end
  end

  always_comb begin
    logic [5:0] hit;
    state_d = state_q;
    key_d   = key_q;
    hit     = 6'd0;
    if (scan_valid_q) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code_q == 8'hE0) begin
            state_d = ST_EXT;
          end else if (scan_code_q == 8'hF0) begin
            state_d = ST_BRK;
          end else begin
            hit = lookup_normal(scan_code_q);
            if (hit[5]) key_d = hit[4:0];
          end
        end
        ST_EXT: begin
          if (scan_code_q == 8'hF0) begin
            state_d = ST_EXT_BRK;
          end else begin
            hit = lookup_ext(scan_code_q);
            if (hit[5]) key_d = hit[4:0];
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkout) begin
    if (reset) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      clk_prev_q   <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 10'd0;
      idle_cnt_q   <= '0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      state_q      <= ST_IDLE;
      key_q        <= IDLE_CODE;
    end else begin
      clk_s1_q     <= clk_s1_d;
      clk_s2_q     <= clk_s2_d;
      clk_prev_q   <= clk_prev_d;
      dat_s1_q     <= dat_s1_d;
      dat_s2_q     <= dat_s2_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      idle_cnt_q   <= idle_cnt_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      state_q      <= state_d;
      key_q        <= key_d;
    end
  end

  assign keystroke  = key_q;
  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus random key traffic,
// compared every cycle against a byte-level behavioural model.
module tb_ps2_keyboard;

  logic       clkout = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [4:0] keystroke;
  logic [7:0] scan_code;
  logic       scan_valid;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int stop_cyc   = -100;
  int strobe_cnt = 0;
  bit chk_en     = 1'b0;

  logic [4:0] model_key;
  bit         model_ext;
  bit         model_brk;
  logic [7:0] pending[$];

  ps2_keyboard dut (
    .clkout    (clkout),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keystroke (keystroke),
    .scan_code (scan_code),
    .scan_valid(scan_valid)
  );

  always #10 clkout = ~clkout;

  function automatic int key_of(input bit ext, input logic [7:0] code);
    logic [7:0] normal_codes[4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    logic [7:0] arrow_codes[4]  = '{8'h75, 8'h72, 8'h6B, 8'h74};
    for (int i = 0; i < 4; i++) begin
      if (!ext && code == normal_codes[i]) return 4 + i;
      if (ext && code == arrow_codes[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    model_key = 5'h1F;
    model_ext = 1'b0;
    model_brk = 1'b0;
    pending.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (model_brk) begin
      model_brk = 1'b0;
      model_ext = 1'b0;
    end else if (b == 8'hF0) begin
      model_brk = 1'b1;
    end else if (b == 8'hE0 && !model_ext) begin
      model_ext = 1'b1;
    end else begin
      k = key_of(model_ext, b);
      if (k >= 0) model_key = 5'(k);
      model_ext = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clkout) begin
    cyc++;
    if (chk_en) begin
      if (scan_valid) begin
        strobe_cnt++;
        vectors++;
        if (pending.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_strobe: got scan_code %0h with nothing expected", scan_code);
        end else begin
          if (scan_code !== pending[0]) begin
            miscompares++;
            $display("FAIL scan_code: got %0h expected %0h", scan_code, pending[0]);
          end
          void'(pending.pop_front());
        end
      end else if (pending.size() > 0 && cyc - stop_cyc > 5) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_strobe: got none expected scan_code %0h", pending[0]);
        void'(pending.pop_front());
      end
      if (cyc - stop_cyc >= 5) begin
        vectors++;
        if (keystroke !== model_key) begin
          miscompares++;
          $display("FAIL keystroke: got %0h expected %0h at cycle %0d", keystroke, model_key, cyc);
        end
      end
    end
  end

  // Drives the first nbits of a frame; nbits == 11 is a complete frame.
  task automatic send(input logic [7:0] b, input bit bad_par = 1'b0, input int nbits = 11);
    logic [10:0] fr;
    int h;
    fr = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      h = $urandom_range(4, 12);
      @(negedge clkout);
      ps2_data = fr[i];
      repeat (h) @(negedge clkout);
      ps2_clk = 1'b0;
      if (i == 10) begin
        stop_cyc = cyc;
        if (!bad_par) begin
          pending.push_back(b);
          model_byte(b);
        end
      end
      repeat (h) @(negedge clkout);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (20) @(negedge clkout);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clkout);
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(negedge clkout);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clkout);
  endtask

  initial begin
    int s0;
    logic [7:0] pool[13] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B,
                             8'h74, 8'hE0, 8'hF0, 8'h2B, 8'hE1, 8'h00};
    logic [7:0] b;
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    do_reset();
    chk("reset_keystroke", 32'(keystroke), 32'h1F);
    chk("reset_scan_valid", 32'(scan_valid), 32'h0);
    chk("reset_scan_code", 32'(scan_code), 32'h00);
    chk_en = 1'b1;

    s0 = strobe_cnt;
    send(8'h1D);
    chk("w_key", 32'(keystroke), 32'b00100);
    chk("w_code", 32'(scan_code), 32'h1D);
    chk("w_one_strobe", 32'(strobe_cnt - s0), 32'd1);

    send(8'hE0); send(8'h75);
    chk("up_key", 32'(keystroke), 32'b00000);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_release", 32'(keystroke), 32'b00000);
    send(8'hF0); send(8'h1D); send(8'h23);
    chk("d_after_break", 32'(keystroke), 32'b00111);

    s0 = strobe_cnt;
    send(8'h1B, 1'b1);
    chk("parity_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("parity_key", 32'(keystroke), 32'b00111);

    send(8'h1B, 1'b0, 5);
    repeat (6000) @(negedge clkout);
    send(8'h1B);
    chk("timeout_key", 32'(keystroke), 32'b00101);

    send(8'h2B);
    chk("f_key_ignored", 32'(keystroke), 32'b00101);
    send(8'h75);
    chk("keypad_ignored", 32'(keystroke), 32'b00101);

    send(8'h1C, 1'b0, 4);
    do_reset();
    chk("midreset_key", 32'(keystroke), 32'h1F);
    chk_en = 1'b1;
    send(8'h1C);
    chk("a_after_reset", 32'(keystroke), 32'b00110);

    for (int n = 0; n < 50; n++) begin
      b = pool[$urandom_range(0, 12)];
      if (b == 8'h00) b = 8'($urandom_range(0, 255));
      send(b, ($urandom_range(0, 9) == 0));
    end
    repeat (10) @(negedge clkout);
    chk("final_key", 32'(keystroke), 32'(model_key));
    chk("no_pending", 32'(pending.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
